// File: rtl/sal_bk_ctrl.sv
// rtl/sal_bk_ctrl.sv - per-bank DDR2 controller: open-row tracking, command sequencing, bank timing
//
// Purpose: sequences ACT/RD/WR/PRE/REF for one DDR2 bank. Each command request
// is held until the bank scheduler grants it. tRCD, tRAS, tRP, tRFC, tRTP and
// tWR are enforced locally.
// Build option: define SAL_BK_CLOSE_PAGE_EN for the close-page policy, which
// precharges after every access. The default build uses the open-page policy.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    access request handshake (req_ready = RD/WR grant)
//   req_wr/req_row/req_col request type and address
//   ref_req_i/ref_ack_o    refresh level request / one-cycle completion pulse
//   act/rd/wr/pre/ref_req  command requests to the bank scheduler
//   act/rd/wr/pre/ref_gnt  grants from the bank scheduler
//   cmd_row/cmd_col        address for the requested command
module sal_bk_ctrl #(
  parameter int ROW_W = 14,
  parameter int COL_W = 10,
  parameter int CNT_W = 5,
  parameter int TRCD  = 3,
  parameter int TRAS  = 8,
  parameter int TRP   = 3,
  parameter int TRFC  = 26,
  parameter int TRTP  = 2,
  parameter int TWR   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             ref_req_i,
  output logic             ref_ack_o,
  output logic             act_req,
  output logic             rd_req,
  output logic             wr_req,
  output logic             pre_req,
  output logic             ref_req,
  input  logic             act_gnt,
  input  logic             rd_gnt,
  input  logic             wr_gnt,
  input  logic             pre_gnt,
  input  logic             ref_gnt,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVATING, S_ACTIVE, S_PRECHARGING, S_REFRESHING
  } state_t;

  // Counters hold N-1 after a grant so they reach 0 exactly N cycles later.
  localparam logic [CNT_W-1:0] L_RCD = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] L_RAS = CNT_W'(TRAS - 1);
  localparam logic [CNT_W-1:0] L_RP  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] L_RFC = CNT_W'(TRFC - 1);
  localparam logic [CNT_W-1:0] L_RTP = CNT_W'(TRTP - 1);
  localparam logic [CNT_W-1:0] L_WR  = CNT_W'(TWR - 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_open_row;
  logic [CNT_W-1:0] r_cnt;      // tRCD / tRP / tRFC, one at a time
  logic [CNT_W-1:0] r_ras;
  logic [CNT_W-1:0] r_rec;      // shared RD/WR recovery before PRE
  logic [CNT_W-1:0] w_rec_dec;
  logic             r_ref_ack;
  logic             w_act, w_rd, w_wr, w_pre, w_ref;
  logic             w_act_go, w_rd_go, w_wr_go, w_pre_go, w_ref_go;
  logic             w_ref_pend, w_hit, w_pre_need, w_pre_ok;
`ifdef SAL_BK_CLOSE_PAGE_EN
  logic             r_closing;  // an access was granted on the open row
`endif

  // ref_req_i is still high during the ack cycle; masking it there prevents
  // a second back-to-back refresh.
  assign w_ref_pend = ref_req_i & ~r_ref_ack;
  assign w_hit      = (req_row == r_open_row);
  assign w_pre_ok   = (r_ras == '0) && (r_rec == '0);
`ifdef SAL_BK_CLOSE_PAGE_EN
  assign w_pre_need = w_ref_pend | (req_valid & ~w_hit) | r_closing;
`else
  assign w_pre_need = w_ref_pend | (req_valid & ~w_hit);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_act = 1'b0;
    w_rd  = 1'b0;
    w_wr  = 1'b0;
    w_pre = 1'b0;
    w_ref = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ref_pend) begin
          w_ref = 1'b1;
          if (ref_gnt) w_state_nxt = (TRFC > 1) ? S_REFRESHING : S_IDLE;
        end else if (req_valid) begin
          w_act = 1'b1;
          if (act_gnt) w_state_nxt = (TRCD > 1) ? S_ACTIVATING : S_ACTIVE;
        end
      end
      // Leave one cycle early so ACTIVE starts as the tRCD count hits 0.
      S_ACTIVATING: if (r_cnt <= C_ONE) w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (w_pre_need) begin
          if (w_pre_ok) begin
            w_pre = 1'b1;
            if (pre_gnt) w_state_nxt = (TRP > 1) ? S_PRECHARGING : S_IDLE;
          end
        end else if (req_valid) begin
          w_rd = ~req_wr;
          w_wr = req_wr;
        end
      end
      S_PRECHARGING: if (r_cnt <= C_ONE) w_state_nxt = S_IDLE;
      S_REFRESHING:  if (r_cnt <= C_ONE) w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Requests drop as soon as rst rises, without waiting for a clock edge.
  assign act_req   = w_act & ~rst;
  assign rd_req    = w_rd  & ~rst;
  assign wr_req    = w_wr  & ~rst;
  assign pre_req   = w_pre & ~rst;
  assign ref_req   = w_ref & ~rst;
  assign w_act_go  = act_req & act_gnt;
  assign w_rd_go   = rd_req  & rd_gnt;
  assign w_wr_go   = wr_req  & wr_gnt;
  assign w_pre_go  = pre_req & pre_gnt;
  assign w_ref_go  = ref_req & ref_gnt;
  assign req_ready = w_rd_go | w_wr_go;
  assign ref_ack_o = r_ref_ack;
  assign cmd_row   = req_row;
  assign cmd_col   = req_col;
  assign w_rec_dec = (r_rec != '0) ? (r_rec - C_ONE) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_open_row <= '0;
      r_cnt      <= '0;
      r_ras      <= '0;
      r_rec      <= '0;
      r_ref_ack  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ref_ack <= (w_state_nxt == S_IDLE) && ((r_state == S_REFRESHING) || w_ref_go);
      if (w_act_go) r_open_row <= req_row;
      if (w_act_go)           r_cnt <= L_RCD;
      else if (w_pre_go)      r_cnt <= L_RP;
      else if (w_ref_go)      r_cnt <= L_RFC;
      else if (r_cnt != '0)   r_cnt <= r_cnt - C_ONE;
      if (w_act_go)           r_ras <= L_RAS;
      else if (r_ras != '0)   r_ras <= r_ras - C_ONE;
      // Keep the later of the pending and the new recovery deadline.
      if (w_rd_go)            r_rec <= (w_rec_dec > L_RTP) ? w_rec_dec : L_RTP;
      else if (w_wr_go)       r_rec <= (w_rec_dec > L_WR) ? w_rec_dec : L_WR;
      else                    r_rec <= w_rec_dec;
    end
  end

`ifdef SAL_BK_CLOSE_PAGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_closing <= 1'b0;
    end else if (w_rd_go || w_wr_go) begin
      r_closing <= 1'b1;
    end else if (w_pre_go) begin
      r_closing <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// tb/tb_sal_bk_ctrl.sv - self-checking bench for sal_bk_ctrl
module tb_sal_bk_ctrl;
  localparam int TRCD = 3, TRAS = 8, TRP = 3, TRFC = 26, TRTP = 2, TWR = 6;
  localparam logic [4:0] V_NONE = 5'b00000, V_ACT = 5'b10000, V_RD = 5'b01000;
  localparam logic [4:0] V_WR = 5'b00100, V_PRE = 5'b00010, V_REF = 5'b00001;

  logic        clk, rst, req_valid, req_ready, req_wr, ref_req_i, ref_ack_o;
  logic [13:0] req_row, cmd_row;
  logic [9:0]  req_col, cmd_col;
  logic        act_req, rd_req, wr_req, pre_req, ref_req;
  logic        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [4:0]  reqs;
  assign reqs = {act_req, rd_req, wr_req, pre_req, ref_req};

  sal_bk_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_row(req_row), .req_col(req_col),
    .ref_req_i(ref_req_i), .ref_ack_o(ref_ack_o),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .cmd_row(cmd_row), .cmd_col(cmd_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, now = 0;

  // Reference model: bank open/row plus absolute grant times.
  bit          m_open, m_used;
  logic [13:0] m_row;
  int          m_t_act, m_t_pre, m_t_ref, m_t_rd, m_t_wr;

  typedef struct { bit wr; logic [13:0] row; logic [9:0] col; } rq_t;
  rq_t q[$];

  task cyc_start();
    @(posedge clk);
    #2;
    now++;
    act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0; ref_gnt = 0;
  endtask

  task apply_reset();
    rst = 1; req_valid = 0; ref_req_i = 0; req_wr = 0;
    act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0; ref_gnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  task automatic wait_req(input logic [4:0] v, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      cyc_start();
      #2;
      if (reqs === v) begin
        when = now;
        return;
      end
    end
  endtask

  function automatic logic [4:0] model_exp();
    bit pend, need;
    pend = ref_req_i && (now != m_t_ref + TRFC);
    if (!m_open) begin
      if (now < m_t_pre + TRP || now < m_t_ref + TRFC) return V_NONE;
      if (pend) return V_REF;
      if (req_valid) return V_ACT;
      return V_NONE;
    end
    if (now < m_t_act + TRCD) return V_NONE;
    need = pend || (req_valid && req_row != m_row);
`ifdef SAL_BK_CLOSE_PAGE_EN
    need = need || m_used;
`endif
    if (need) begin
      if (now >= m_t_act + TRAS && now >= m_t_rd + TRTP && now >= m_t_wr + TWR) return V_PRE;
      return V_NONE;
    end
    if (req_valid) return req_wr ? V_WR : V_RD;
    return V_NONE;
  endfunction

  task test_reset();
    rst = 1; req_valid = 1; req_wr = 0; req_row = 14'h12; req_col = 10'h5; ref_req_i = 1;
    act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0; ref_gnt = 0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (reqs !== V_NONE) begin n_errors++; $display("FAIL reset_reqs: got %b expected %b", reqs, V_NONE); end
    n_checks++; if (ref_ack_o !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", ref_ack_o); end
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    rst = 0; ref_req_i = 0;
    #2;
    n_checks++; if (reqs !== V_ACT) begin n_errors++; $display("FAIL reset_first_act: got %b expected %b", reqs, V_ACT); end
    req_valid = 0;
  endtask

  task test_read_hit();
    int t;
    apply_reset();
    req_valid = 1; req_wr = 0; req_row = 14'h12; req_col = 10'h5;
    wait_req(V_ACT, 10, t);
    n_checks++; if (t < 0) begin n_errors++; $display("FAIL read_act_timeout: got none expected act_req"); end
    n_checks++; if (cmd_row !== 14'h12) begin n_errors++; $display("FAIL read_cmd_row: got %h expected 12", cmd_row); end
    act_gnt = 1;
    for (int c = 1; c <= 3; c++) begin
      cyc_start();
      #2;
      n_checks++;
      if (reqs !== ((c == 3) ? V_RD : V_NONE)) begin
        n_errors++; $display("FAIL read_trcd_c%0d: got %b expected %b", c, reqs, (c == 3) ? V_RD : V_NONE);
      end
    end
    n_checks++; if (cmd_col !== 10'h5) begin n_errors++; $display("FAIL read_cmd_col: got %h expected 5", cmd_col); end
    rd_gnt = 1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL read_ready: got %b expected 1", req_ready); end
  endtask

  task test_back_to_back();
    logic [4:0] exp;
    for (int k = 0; k < 6; k++) begin
      cyc_start();
      req_col = 10'(6 + k);
      req_wr = (k >= 2) && (k % 2 == 1);
      #2;
      exp = req_wr ? V_WR : V_RD;
      n_checks++;
      if (reqs !== exp) begin n_errors++; $display("FAIL b2b_k%0d: got %b expected %b", k, reqs, exp); end
      if (req_wr) wr_gnt = 1; else rd_gnt = 1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_k%0d: got %b expected 1", k, req_ready); end
    end
    cyc_start();
    req_valid = 0; req_wr = 0;
  endtask

  task test_row_miss();
    int t;
    logic [4:0] exp;
    apply_reset();
    req_valid = 1; req_wr = 0; req_row = 14'h12; req_col = 10'h5;
    wait_req(V_ACT, 10, t);
    n_checks++; if (t < 0) begin n_errors++; $display("FAIL miss_act_timeout: got none expected act_req"); end
    act_gnt = 1;
    for (int c = 1; c <= 11; c++) begin
      cyc_start();
      if (c == 1) req_valid = 0;
      if (c == 3) begin req_valid = 1; req_row = 14'h34; end
      #2;
      exp = (c == 8) ? V_PRE : (c == 11) ? V_ACT : V_NONE;
      n_checks++;
      if (reqs !== exp) begin n_errors++; $display("FAIL miss_c%0d: got %b expected %b", c, reqs, exp); end
      if (c == 8) pre_gnt = 1;
      if (c == 11) begin
        n_checks++;
        if (cmd_row !== 14'h34) begin n_errors++; $display("FAIL miss_cmd_row: got %h expected 34", cmd_row); end
        act_gnt = 1;
      end
    end
    cyc_start();
    req_valid = 0;
  endtask

  task test_wr_recovery();
    int t;
    logic [4:0] exp;
    apply_reset();
    req_valid = 1; req_wr = 1; req_row = 14'h12; req_col = 10'h9;
    wait_req(V_ACT, 10, t);
    n_checks++; if (t < 0) begin n_errors++; $display("FAIL wr_act_timeout: got none expected act_req"); end
    act_gnt = 1;
    for (int c = 1; c <= 11; c++) begin
      cyc_start();
      if (c == 6) begin req_wr = 0; req_row = 14'h34; end
      #2;
      exp = (c == 11) ? V_PRE : (c >= 3 && c <= 5) ? V_WR : V_NONE;
      n_checks++;
      if (reqs !== exp) begin n_errors++; $display("FAIL wr_rec_c%0d: got %b expected %b", c, reqs, exp); end
      if (c == 5) wr_gnt = 1;
      if (c == 11) pre_gnt = 1;
    end
    cyc_start();
    req_valid = 0;
  endtask

  task test_refresh();
    int t;
    logic [4:0] exp;
    apply_reset();
    req_valid = 1; req_wr = 0; req_row = 14'h12; req_col = 10'h5;
    wait_req(V_ACT, 10, t);
    n_checks++; if (t < 0) begin n_errors++; $display("FAIL ref_act_timeout: got none expected act_req"); end
    act_gnt = 1;
    for (int c = 1; c <= 11; c++) begin
      cyc_start();
      if (c == 4) begin ref_req_i = 1; req_col = 10'h6; end
      #2;
      exp = (c == 3) ? V_RD : (c == 8) ? V_PRE : (c == 11) ? V_REF : V_NONE;
      n_checks++;
      if (reqs !== exp) begin n_errors++; $display("FAIL ref_seq_c%0d: got %b expected %b", c, reqs, exp); end
      if (c == 3) rd_gnt = 1;
      if (c == 8) pre_gnt = 1;
      if (c == 11) ref_gnt = 1;
    end
    for (int d = 1; d <= TRFC; d++) begin
      cyc_start();
      #2;
      if (d < TRFC) begin
        n_checks++;
        if ({reqs, ref_ack_o} !== 6'b0) begin
          n_errors++; $display("FAIL ref_busy_d%0d: got %b expected 000000", d, {reqs, ref_ack_o});
        end
      end else begin
        n_checks++;
        if (ref_ack_o !== 1'b1 || ref_req !== 1'b0) begin
          n_errors++; $display("FAIL ref_ack_trfc: got ack=%b ref_req=%b expected ack=1 ref_req=0", ref_ack_o, ref_req);
        end
      end
    end
    cyc_start();
    ref_req_i = 0;
    #2;
    n_checks++; if (ref_ack_o !== 1'b0) begin n_errors++; $display("FAIL ref_ack_pulse: got %b expected 0", ref_ack_o); end
    if (reqs === V_ACT) t = now; else wait_req(V_ACT, 5, t);
    n_checks++; if (t < 0) begin n_errors++; $display("FAIL ref_reopen: got none expected act_req"); end
    act_gnt = 1;
    wait_req(V_RD, 10, t);
    n_checks++; if (t < 0) begin n_errors++; $display("FAIL ref_hit_served: got none expected rd_req"); end
    rd_gnt = 1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL ref_hit_ready: got %b expected 1", req_ready); end
    cyc_start();
    req_valid = 0;
  endtask

  task test_reset_mid();
    int t;
    apply_reset();
    req_valid = 1; req_wr = 0; req_row = 14'h12; req_col = 10'h5;
    wait_req(V_ACT, 10, t);
    act_gnt = 1;
    cyc_start();
    #1 rst = 1;
    #1;
    n_checks++; if ({reqs, ref_ack_o} !== 6'b0) begin n_errors++; $display("FAIL rstmid_drop: got %b expected 000000", {reqs, ref_ack_o}); end
    cyc_start();
    rst = 0;
    #2;
    n_checks++; if (reqs !== V_ACT) begin n_errors++; $display("FAIL rstmid_restart: got %b expected %b", reqs, V_ACT); end
    #1 rst = 1;
    #1;
    n_checks++; if (act_req !== 1'b0) begin n_errors++; $display("FAIL rstmid_async: got %b expected 0", act_req); end
    cyc_start();
    rst = 0; req_valid = 0;
  endtask

`ifdef SAL_BK_CLOSE_PAGE_EN
  task test_close_page();
    int t;
    logic [4:0] exp;
    apply_reset();
    req_valid = 1; req_wr = 0; req_row = 14'h12; req_col = 10'h5;
    wait_req(V_ACT, 10, t);
    act_gnt = 1;
    for (int c = 1; c <= 11; c++) begin
      cyc_start();
      if (c == 4) req_col = 10'h6;
      #2;
      exp = (c == 3) ? V_RD : (c == 8) ? V_PRE : (c == 11) ? V_ACT : V_NONE;
      n_checks++;
      if (reqs !== exp) begin n_errors++; $display("FAIL close_c%0d: got %b expected %b", c, reqs, exp); end
      if (c == 3) rd_gnt = 1;
      if (c == 8) pre_gnt = 1;
      if (c == 11) act_gnt = 1;
    end
    cyc_start();
    req_valid = 0;
  endtask
`endif

  task test_random();
    logic [13:0] rows [3];
    logic [4:0]  exp;
    bit          pop_pending, ack_seen, exp_ack, granted_rw;
    rq_t         r;
    rows[0] = 14'h12; rows[1] = 14'h34; rows[2] = 14'h56;
    apply_reset();
    q.delete();
    m_open = 0; m_used = 0; m_row = '0;
    m_t_act = -1000; m_t_pre = -1000; m_t_ref = -1000; m_t_rd = -1000; m_t_wr = -1000;
    pop_pending = 0; ack_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc_start();
      if (pop_pending) void'(q.pop_front());
      pop_pending = 0;
      if (q.size() < 4 && $urandom_range(0, 2) == 0) begin
        r.wr = $urandom_range(0, 1) == 1;
        r.row = rows[$urandom_range(0, 2)];
        r.col = 10'($urandom);
        q.push_back(r);
      end
      req_valid = q.size() > 0;
      if (q.size() > 0) begin req_wr = q[0].wr; req_row = q[0].row; req_col = q[0].col; end
      if (ack_seen) begin ref_req_i = 0; ack_seen = 0; end
      else if (!ref_req_i && $urandom_range(0, 149) == 0) ref_req_i = 1;
      #2;
      exp = model_exp();
      exp_ack = (now == m_t_ref + TRFC);
      n_checks++;
      if (reqs !== exp) begin n_errors++; $display("FAIL rand_req_cyc%0d: got %b expected %b", i, reqs, exp); end
      n_checks++;
      if (ref_ack_o !== exp_ack) begin n_errors++; $display("FAIL rand_ack_cyc%0d: got %b expected %b", i, ref_ack_o, exp_ack); end
      if (exp == V_ACT) begin
        n_checks++;
        if (cmd_row !== req_row) begin n_errors++; $display("FAIL rand_row_cyc%0d: got %h expected %h", i, cmd_row, req_row); end
      end
      granted_rw = 0;
      if (reqs === exp && exp != V_NONE && $urandom_range(0, 9) < 7) begin
        case (exp)
          V_ACT: begin act_gnt = 1; m_open = 1; m_row = req_row; m_t_act = now; m_used = 0; end
          V_RD:  begin rd_gnt = 1; m_t_rd = now; m_used = 1; granted_rw = 1; end
          V_WR:  begin wr_gnt = 1; m_t_wr = now; m_used = 1; granted_rw = 1; end
          V_PRE: begin pre_gnt = 1; m_open = 0; m_t_pre = now; end
          default: begin ref_gnt = 1; m_t_ref = now; end
        endcase
      end
      #1;
      n_checks++;
      if (req_ready !== granted_rw) begin n_errors++; $display("FAIL rand_ready_cyc%0d: got %b expected %b", i, req_ready, granted_rw); end
      if (granted_rw) pop_pending = 1;
      if (ref_ack_o) ack_seen = 1;
    end
    cyc_start();
    req_valid = 0; ref_req_i = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_wr = 0; req_row = '0; req_col = '0; ref_req_i = 0;
    act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0; ref_gnt = 0;
    test_reset();
`ifdef SAL_BK_CLOSE_PAGE_EN
    test_close_page();
`else
    test_read_hit();
    test_back_to_back();
    test_row_miss();
    test_wr_recovery();
    test_refresh();
`endif
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
